// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared VGA timing defaults, TinyVGA PMOD pin map, total helper.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int c_pmod_r1 = 0;
  localparam int c_pmod_g1 = 1;
  localparam int c_pmod_b1 = 2;
  localparam int c_pmod_vs = 3;
  localparam int c_pmod_r0 = 4;
  localparam int c_pmod_g0 = 5;
  localparam int c_pmod_b0 = 6;
  localparam int c_pmod_hs = 7;

  // 640x480 at 60 Hz, 25.175 MHz nominal pixel clock
  localparam int c_vga_h_active = 640;
  localparam int c_vga_h_fp     = 16;
  localparam int c_vga_h_sync   = 96;
  localparam int c_vga_h_bp     = 48;
  localparam int c_vga_v_active = 480;
  localparam int c_vga_v_fp     = 10;
  localparam int c_vga_v_sync   = 2;
  localparam int c_vga_v_bp     = 33;

  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module   : vga_axis_counter
// Purpose  : One raster axis: wrapping position counter with active/sync/last.
// Revision : 1.0 - initial release
// ============================================================================
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = c_vga_h_active,
  parameter int FP     = c_vga_h_fp,
  parameter int SYNC   = c_vga_h_sync,
  parameter int BP     = c_vga_h_bp,
  parameter bit POL    = 1'b0,
  localparam int W     = $clog2(vga_total(ACTIVE, FP, SYNC, BP))
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         active,
  output logic         sync,
  output logic         last
);

  localparam int            c_total    = vga_total(ACTIVE, FP, SYNC, BP);
  localparam logic [W-1:0]  c_last_val = W'(c_total - 1);
  localparam logic [W-1:0]  c_act_end  = W'(ACTIVE);
  localparam logic [W-1:0]  c_sync_lo  = W'(ACTIVE + FP);
  localparam logic [W-1:0]  c_sync_hi  = W'(ACTIVE + FP + SYNC);

  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_timing
    $error("vga_axis_counter: every timing segment must be at least 1");
  end

  logic [W-1:0] r_count;
  logic         w_in_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (step) begin
      r_count <= last ? '0 : r_count + 1'b1;
    end
  end

  assign w_in_sync = (r_count >= c_sync_lo) && (r_count < c_sync_hi);
  assign count     = r_count;
  assign last      = (r_count == c_last_val);
  assign active    = (r_count < c_act_end);
  assign sync      = POL ? w_in_sync : ~w_in_sync;

endmodule
`default_nettype wire

// File: rtl/vga_timing_pmod.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pmod
// Purpose  : VGA raster timing with blanked RGB packed onto the TinyVGA PMOD.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_pmod
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = c_vga_h_active,
  parameter int H_FP     = c_vga_h_fp,
  parameter int H_SYNC   = c_vga_h_sync,
  parameter int H_BP     = c_vga_h_bp,
  parameter int V_ACTIVE = c_vga_v_active,
  parameter int V_FP     = c_vga_v_fp,
  parameter int V_SYNC   = c_vga_v_sync,
  parameter int V_BP     = c_vga_v_bp,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 2,
  parameter int FRAME_W  = 8,
  localparam int XW      = $clog2(vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  localparam int YW      = $clog2(vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [3*CW-1:0]    rgb_in,
  output logic [XW-1:0]      x,
  output logic [YW-1:0]      y,
  output logic               active,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic [7:0]         uo_out
);

  localparam logic [7:0] c_uo_idle = (8'(!HS_POL) << c_pmod_hs) | (8'(!VS_POL) << c_pmod_vs);

  logic w_h_active, w_h_sync, w_h_last;
  logic w_v_active, w_v_sync, w_v_last;
  logic w_v_step;
  logic [1:0] w_r, w_g, w_b;
  logic [1:0] w_r_vis, w_g_vis, w_b_vis;
  logic [7:0] w_pmod;
  logic [7:0] r_uo;
  logic [FRAME_W-1:0] r_frame_cnt;

  assign w_v_step = en & w_h_last;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP), .POL (HS_POL)
  ) u_h_axis (
    .clk (clk), .rst (rst), .step (en),
    .count (x), .active (w_h_active), .sync (w_h_sync), .last (w_h_last)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP), .POL (VS_POL)
  ) u_v_axis (
    .clk (clk), .rst (rst), .step (w_v_step),
    .count (y), .active (w_v_active), .sync (w_v_sync), .last (w_v_last)
  );

  // Single-bit channels drive both pins so a lit channel reaches full scale
  if (CW == 2) begin : g_cw2
    assign w_r = rgb_in[5:4];
    assign w_g = rgb_in[3:2];
    assign w_b = rgb_in[1:0];
  end else if (CW == 1) begin : g_cw1
    assign w_r = {2{rgb_in[2]}};
    assign w_g = {2{rgb_in[1]}};
    assign w_b = {2{rgb_in[0]}};
  end else begin : g_bad_cw
    $error("vga_timing_pmod: CW must be 1 or 2");
    assign w_r = '0;
    assign w_g = '0;
    assign w_b = '0;
  end

  assign active      = w_h_active & w_v_active;
  assign line_start  = en & (x == '0);
  assign frame_start = line_start & (y == '0);

  assign w_r_vis = active ? w_r : 2'b00;
  assign w_g_vis = active ? w_g : 2'b00;
  assign w_b_vis = active ? w_b : 2'b00;

  always_comb begin
    w_pmod            = '0;
    w_pmod[c_pmod_hs] = w_h_sync;
    w_pmod[c_pmod_vs] = w_v_sync;
    w_pmod[c_pmod_r1] = w_r_vis[1];
    w_pmod[c_pmod_r0] = w_r_vis[0];
    w_pmod[c_pmod_g1] = w_g_vis[1];
    w_pmod[c_pmod_g0] = w_g_vis[0];
    w_pmod[c_pmod_b1] = w_b_vis[1];
    w_pmod[c_pmod_b0] = w_b_vis[0];
  end

  // Syncs and colour share this register so they stay aligned at the pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_uo <= c_uo_idle;
    end else if (en) begin
      r_uo <= w_pmod;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (w_v_step & w_v_last) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign uo_out    = r_uo;
  assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_pmod.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_pmod
// Purpose  : Directed self-checking bench for default and reduced timing configs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_pmod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en;
  logic [5:0] rgb_in;
  logic [9:0] x, y;
  logic       active, line_start, frame_start;
  logic [7:0] frame_cnt, uo_out;

  vga_timing_pmod dut (
    .clk (clk), .rst (rst), .en (en), .rgb_in (rgb_in),
    .x (x), .y (y), .active (active), .line_start (line_start),
    .frame_start (frame_start), .frame_cnt (frame_cnt), .uo_out (uo_out)
  );

  logic       rst_s, en_s;
  logic [2:0] rgb_s;
  logic [3:0] x_s;
  logic [2:0] y_s;
  logic       active_s, ls_s, fs_s;
  logic [7:0] fc_s, uo_s;

  vga_timing_pmod #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL (1'b1), .VS_POL (1'b0), .CW (1), .FRAME_W (8)
  ) dut_s (
    .clk (clk), .rst (rst_s), .en (en_s), .rgb_in (rgb_s),
    .x (x_s), .y (y_s), .active (active_s), .line_start (ls_s),
    .frame_start (fs_s), .frame_cnt (fc_s), .uo_out (uo_s)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int hs_first, hs_cnt0, ls_cnt, ls_first, fs_cnt, act_cnt, vs_low;
  int xm, ym, bad_x, bad_uo;
  int mx, my, mfc, bad_s, fs_cnt_s, fs_first;
  logic [7:0] uo_prev, uo_exp;
  logic       hs_e, vs_e, act_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; rgb_in = '0;
    rst_s = 1'b1; en_s = 1'b0; rgb_s = '0;
    tick; tick;

    // Reset state
    check("rst_uo", 32'(uo_out), 32'h88);
    check("rst_x", 32'(x), 0);
    check("rst_y", 32'(y), 0);
    check("rst_fcnt", 32'(frame_cnt), 0);
    check("rst_uo_small", 32'(uo_s), 32'h08);

    // Asynchronous reset between edges
    rst = 1'b0; en = 1'b1; rgb_in = 6'h3f;
    repeat (5) tick;
    check("run_x", 32'(x), 5);
    check("run_uo", 32'(uo_out), 32'hff);
    #2 rst = 1'b1;
    #1;
    check("async_x", 32'(x), 0);
    check("async_uo", 32'(uo_out), 32'h88);
    tick;
    rst = 1'b0; rgb_in = '0;
    #1;
    check("frame_start_00", 32'(frame_start), 1);

    // Horizontal timing over two lines
    hs_first = 0; hs_cnt0 = 0; ls_cnt = 0; ls_first = 0; fs_cnt = 0; act_cnt = 0; vs_low = 0;
    for (int n = 1; n <= 1600; n++) begin
      tick;
      if (!uo_out[7]) begin
        if (n <= 800) hs_cnt0++;
        if (hs_first == 0) hs_first = n;
      end
      if (line_start) begin
        ls_cnt++;
        if (ls_first == 0) ls_first = n;
      end
      if (frame_start) fs_cnt++;
      if (active) act_cnt++;
      if (!uo_out[3]) vs_low++;
    end
    check("hs_first_low", 32'(hs_first), 657);
    check("hs_width", 32'(hs_cnt0), 96);
    check("ls_first", 32'(ls_first), 800);
    check("ls_count", 32'(ls_cnt), 2);
    check("fs_none", 32'(fs_cnt), 0);
    check("active_cnt", 32'(act_cnt), 1280);
    check("vs_idle", 32'(vs_low), 0);
    check("y_after_2lines", 32'(y), 2);
    check("x_after_2lines", 32'(x), 0);

    // Packing and blanking
    rst = 1'b1; tick; rst = 1'b0;
    rgb_in = 6'b10_01_11;
    tick;
    check("pack_first", 32'(uo_out), 32'hed);
    repeat (638) tick;
    check("x_639", 32'(x), 639);
    check("active_639", 32'(active), 1);
    tick;
    check("pack_last", 32'(uo_out), 32'hed);
    check("active_640", 32'(active), 0);
    tick;
    check("fp_blank", 32'(uo_out), 32'h88);
    repeat (16) tick;
    check("hsync_blank", 32'(uo_out), 32'h08);

    // Half-rate clock enable
    rst = 1'b1; tick; rst = 1'b0;
    xm = 0; ym = 0; bad_x = 0; bad_uo = 0;
    for (int i = 0; i < 1600; i++) begin
      en = (i % 2 == 0);
      uo_prev = uo_out;
      tick;
      if (en) begin
        xm++;
        if (xm == 800) begin
          xm = 0;
          ym++;
        end
      end else if (uo_out !== uo_prev) begin
        bad_uo++;
      end
      if (x !== 10'(xm) || y !== 10'(ym)) bad_x++;
    end
    check("en_track_xy", 32'(bad_x), 0);
    check("en_hold_uo", 32'(bad_uo), 0);
    check("en_line_x", 32'(x), 0);
    check("en_line_y", 32'(y), 1);
    en = 1'b0; #1;
    check("ls_gated", 32'(line_start), 0);
    en = 1'b1; #1;
    check("ls_enabled", 32'(line_start), 1);
    check("fs_line1", 32'(frame_start), 0);

    // Reduced configuration, three frames against a reference model
    rst_s = 1'b0; en_s = 1'b1; rgb_s = 3'b101;
    mx = 0; my = 0; mfc = 0; bad_s = 0; fs_cnt_s = 0; fs_first = 0;
    for (int n = 1; n <= 294; n++) begin
      hs_e   = (mx >= 10) && (mx < 12);
      vs_e   = !((my >= 5) && (my < 6));
      act_e  = (mx < 8) && (my < 4);
      uo_exp = {hs_e, act_e, 1'b0, act_e, vs_e, act_e, 1'b0, act_e};
      if (mx == 13) begin
        mx = 0;
        if (my == 6) begin
          my = 0;
          mfc++;
        end else begin
          my++;
        end
      end else begin
        mx++;
      end
      tick;
      if (x_s !== 4'(mx) || y_s !== 3'(my) || fc_s !== 8'(mfc) || uo_s !== uo_exp) bad_s++;
      if (fs_s) begin
        fs_cnt_s++;
        if (fs_first == 0) fs_first = n;
      end
      if (n == 1)  check("s_pack_active", 32'(uo_s), 32'h5d);
      if (n == 11) check("s_hsync_high", 32'(uo_s), 32'h88);
      if (n == 71) check("s_vsync_low", 32'(uo_s), 32'h00);
    end
    check("s_model", 32'(bad_s), 0);
    check("s_fs_count", 32'(fs_cnt_s), 3);
    check("s_fs_first", 32'(fs_first), 98);
    check("s_frame_cnt", 32'(fc_s), 3);

    // Mid-line reset and restart
    repeat (5) tick;
    check("s_midline_x", 32'(x_s), 5);
    #2 rst_s = 1'b1;
    #1;
    check("s_rst_x", 32'(x_s), 0);
    check("s_rst_y", 32'(y_s), 0);
    check("s_rst_fcnt", 32'(fc_s), 0);
    check("s_rst_uo", 32'(uo_s), 32'h08);
    tick;
    rst_s = 1'b0;
    tick;
    check("s_restart_x", 32'(x_s), 1);
    check("s_restart_uo", 32'(uo_s), 32'h5d);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
